crt_loader: RTL and testbench

Streaming parser that sits between the ioctl download path and `cartridge`. It watches each byte of a `.CRT` file as it is written to SDRAM and decodes the file header and every CHIP packet header. From these it drives the cartridge configuration bus: `cart_id`, `cart_exrom`, `cart_game`, the per-bank `cart_bank_*` fields with a one-cycle `cart_bank_wr` strobe, and `cart_attached`. It only observes the stream; it never stalls or alters it.

---
 rtl/crt_pkg.sv | 53 +++++
 rtl/crt_be_field.sv | 23 ++
 rtl/crt_loader.sv | 195 +++++++++++++++++++
 tb/tb_crt_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crt_pkg.sv
// Shared types and constants for the .CRT stream parser.
package crt_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_CHIP_HDR,
      S_CHIP_DATA,
      S_DONE,
      S_ERR
   } crt_state_t;

   // "C64 CARTRIDGE   " with file byte 0 in the top byte.
   localparam logic [127:0] HDR_SIG  = 128'h43_36_34_20_43_41_52_54_52_49_44_47_45_20_20_20;
   // "CHIP" with packet byte 0 in the top byte.
   localparam logic [31:0]  CHIP_TAG = 32'h43_48_49_50;

   localparam logic [31:0] HDR_LEN_OFS    = 32'h10;
   localparam logic [31:0] HDR_ID_OFS     = 32'h16;
   localparam logic [31:0] HDR_EXROM_OFS  = 32'h18;
   localparam logic [31:0] HDR_GAME_OFS   = 32'h19;
   localparam logic [31:0] HDR_MIN_LEN    = 32'h40;

   localparam logic [31:0] CHIP_LEN_OFS   = 32'h04;
   localparam logic [31:0] CHIP_TYPE_OFS  = 32'h08;
   localparam logic [31:0] CHIP_BANK_OFS  = 32'h0A;
   localparam logic [31:0] CHIP_LADDR_OFS = 32'h0C;
   localparam logic [31:0] CHIP_SIZE_OFS  = 32'h0E;
   localparam logic [31:0] CHIP_HDR_LEN   = 32'h10;

   function automatic logic [7:0] sig_byte(input logic [3:0] idx);
      logic [127:0] s;
      s = HDR_SIG << {idx, 3'b000};
      return s[127:120];
   endfunction

   function automatic logic [7:0] tag_byte(input logic [1:0] idx);
      logic [31:0] t;
      t = CHIP_TAG << {idx, 3'b000};
      return t[31:24];
   endfunction

   // True when cnt addresses either byte of a 2-byte field at ofs.
   function automatic logic in_pair(input logic [31:0] cnt, input logic [31:0] ofs);
      return (cnt == ofs) || (cnt == ofs + 32'd1);
   endfunction

   // True when cnt addresses any byte of a 4-byte field at ofs.
   function automatic logic in_quad(input logic [31:0] cnt, input logic [31:0] ofs);
      return (cnt >= ofs) && (cnt < ofs + 32'd4);
   endfunction

endpackage

// File: rtl/crt_be_field.sv
// Big-endian field assembler: each enabled byte shifts in at the bottom,
// so after W/8 bytes the first one received sits in the top byte.
module crt_be_field #(
   parameter int W = 16
) (
   input  logic         clk32,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [7:0]   i_byte,
   output logic [W-1:0] o_val
);

   // Shift the next byte in; clear wins over a same-cycle load.
   always_ff @(posedge clk32) begin
      if (reset || i_clr) begin
         o_val <= '0;
      end else if (i_en) begin
         o_val <= {o_val[W-9:0], i_byte};
      end
   end

endmodule

// File: rtl/crt_loader.sv
// Passive .CRT parser: snoops the download byte stream and publishes the
// cartridge header and each CHIP packet header to the cartridge config bus.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no load in progress, bytes ignored
// S_HDR       | inside the file header, r_cnt = file offset
// S_CHIP_HDR  | inside a CHIP header, r_cnt = offset within the header
// S_CHIP_DATA | inside a CHIP payload, r_cnt = payload bytes remaining
// S_DONE      | load finished cleanly, bytes ignored
// S_ERR       | load failed to parse, held until the next load start
module crt_loader
   import crt_pkg::*;
#(
   parameter logic [24:0] DATA_BASE = 25'h0100000
) (
   input  logic        clk32,
   input  logic        reset,
   input  logic        cart_loading,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   output logic [15:0] cart_id,
   output logic [7:0]  cart_exrom,
   output logic [7:0]  cart_game,
   output logic [15:0] cart_bank_num,
   output logic [15:0] cart_bank_laddr,
   output logic [15:0] cart_bank_size,
   output logic [7:0]  cart_bank_type,
   output logic [24:0] cart_bank_raddr,
   output logic        cart_bank_wr,
   output logic        cart_attached,
   output logic        crt_error,
   output logic [7:0]  chip_count
);

   logic        r_loading_d;
   crt_state_t  r_state;
   logic [31:0] r_cnt;

   logic        w_rise, w_fall, w_acc;
   crt_state_t  w_st;
   logic [31:0] w_cnt;
   logic        w_in_hdr, w_in_chip;
   logic [31:0] w_hdr_len, w_hdr_len_eff, w_pkt_len, w_pkt_full, w_remain;

   assign w_rise = cart_loading & ~r_loading_d;
   assign w_fall = ~cart_loading & r_loading_d;
   assign w_acc  = ioctl_wr & cart_loading;

   // A load start re-enters the header at offset 0 even if a byte arrives with it.
   assign w_st  = w_rise ? S_HDR : r_state;
   assign w_cnt = w_rise ? 32'd0 : r_cnt;

   assign w_in_hdr  = w_acc && (w_st == S_HDR);
   assign w_in_chip = w_acc && (w_st == S_CHIP_HDR);

   assign w_hdr_len_eff = (w_hdr_len < HDR_MIN_LEN) ? HDR_MIN_LEN : w_hdr_len;
   // Packet length including the byte being accepted at +7.
   assign w_pkt_full    = {w_pkt_len[23:0], ioctl_data};
   assign w_remain      = w_pkt_len - CHIP_HDR_LEN;

   crt_be_field #(.W(32)) u_hdr_len (
      .clk32(clk32), .reset(reset), .i_clr(w_rise),
      .i_en(w_in_hdr && in_quad(w_cnt, HDR_LEN_OFS)),
      .i_byte(ioctl_data), .o_val(w_hdr_len));

   crt_be_field #(.W(32)) u_pkt_len (
      .clk32(clk32), .reset(reset), .i_clr(w_rise),
      .i_en(w_in_chip && in_quad(w_cnt, CHIP_LEN_OFS)),
      .i_byte(ioctl_data), .o_val(w_pkt_len));

   crt_be_field #(.W(16)) u_id (
      .clk32(clk32), .reset(reset), .i_clr(1'b0),
      .i_en(w_in_hdr && in_pair(w_cnt, HDR_ID_OFS)),
      .i_byte(ioctl_data), .o_val(cart_id));

   crt_be_field #(.W(16)) u_bank (
      .clk32(clk32), .reset(reset), .i_clr(1'b0),
      .i_en(w_in_chip && in_pair(w_cnt, CHIP_BANK_OFS)),
      .i_byte(ioctl_data), .o_val(cart_bank_num));

   crt_be_field #(.W(16)) u_laddr (
      .clk32(clk32), .reset(reset), .i_clr(1'b0),
      .i_en(w_in_chip && in_pair(w_cnt, CHIP_LADDR_OFS)),
      .i_byte(ioctl_data), .o_val(cart_bank_laddr));

   crt_be_field #(.W(16)) u_size (
      .clk32(clk32), .reset(reset), .i_clr(1'b0),
      .i_en(w_in_chip && in_pair(w_cnt, CHIP_SIZE_OFS)),
      .i_byte(ioctl_data), .o_val(cart_bank_size));

   // Load sequencing FSM; later assignments in the block override earlier ones.
   always_ff @(posedge clk32) begin
      if (reset) begin
         // Track the live level so a reset mid-load does not fake a new load start.
         r_loading_d     <= cart_loading;
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         cart_exrom      <= '0;
         cart_game       <= '0;
         cart_bank_type  <= '0;
         cart_bank_raddr <= '0;
         cart_bank_wr    <= 1'b0;
         cart_attached   <= 1'b0;
         crt_error       <= 1'b0;
         chip_count      <= '0;
      end else begin
         r_loading_d  <= cart_loading;
         cart_bank_wr <= 1'b0;

         if (w_rise) begin
            r_state       <= S_HDR;
            r_cnt         <= '0;
            cart_attached <= 1'b0;
            crt_error     <= 1'b0;
            chip_count    <= '0;
         end

         if (w_fall) begin
            case (r_state)
               S_CHIP_HDR: begin
                  if (r_cnt == 32'd0 && chip_count != 8'd0) begin
                     r_state       <= S_DONE;
                     cart_attached <= 1'b1;
                  end else begin
                     r_state       <= S_ERR;
                     crt_error     <= 1'b1;
                     cart_attached <= 1'b0;
                  end
               end
               S_CHIP_DATA: begin
                  r_state       <= S_DONE;
                  cart_attached <= (chip_count != 8'd0);
               end
               S_HDR: begin
                  r_state       <= S_ERR;
                  crt_error     <= 1'b1;
                  cart_attached <= 1'b0;
               end
               default: ;
            endcase
         end else if (w_acc) begin
            case (w_st)
               S_HDR: begin
                  r_cnt <= w_cnt + 32'd1;
                  if (w_cnt < 32'd16 && ioctl_data != sig_byte(w_cnt[3:0])) begin
                     r_state       <= S_ERR;
                     crt_error     <= 1'b1;
                     cart_attached <= 1'b0;
                  end else if (w_cnt == w_hdr_len_eff - 32'd1) begin
                     r_state <= S_CHIP_HDR;
                     r_cnt   <= '0;
                  end
                  if (w_cnt == HDR_EXROM_OFS) cart_exrom <= ioctl_data;
                  if (w_cnt == HDR_GAME_OFS)  cart_game  <= ioctl_data;
               end
               S_CHIP_HDR: begin
                  r_cnt <= w_cnt + 32'd1;
                  if (w_cnt < 32'd4 && ioctl_data != tag_byte(w_cnt[1:0])) begin
                     r_state       <= S_ERR;
                     crt_error     <= 1'b1;
                     cart_attached <= 1'b0;
                  end else if (w_cnt == CHIP_LEN_OFS + 32'd3 && w_pkt_full < CHIP_HDR_LEN) begin
                     r_state       <= S_ERR;
                     crt_error     <= 1'b1;
                     cart_attached <= 1'b0;
                  end else if (w_cnt == CHIP_HDR_LEN - 32'd1) begin
                     cart_bank_raddr <= DATA_BASE + ioctl_addr + 25'd1;
                     cart_bank_wr    <= 1'b1;
                     if (chip_count != 8'hFF) chip_count <= chip_count + 8'd1;
                     if (w_remain == 32'd0) begin
                        r_cnt <= '0;
                     end else begin
                        r_state <= S_CHIP_DATA;
                        r_cnt   <= w_remain;
                     end
                  end
                  if (w_cnt == CHIP_TYPE_OFS + 32'd1) cart_bank_type <= ioctl_data;
               end
               S_CHIP_DATA: begin
                  if (r_cnt == 32'd1) begin
                     r_state <= S_CHIP_HDR;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt - 32'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_crt_loader.sv
// Bench for crt_loader: builds .CRT images in a byte queue, streams them with
// random gaps and edge-case timing, and compares against a file-walking model.
module tb_crt_loader;

   localparam logic [24:0] BASE = 25'h0100000;

   logic        clk32 = 1'b0;
   logic        reset, cart_loading, ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic [15:0] cart_id, cart_bank_num, cart_bank_laddr, cart_bank_size;
   logic [7:0]  cart_exrom, cart_game, cart_bank_type, chip_count;
   logic [24:0] cart_bank_raddr;
   logic        cart_bank_wr, cart_attached, crt_error;

   crt_loader dut (
      .clk32(clk32), .reset(reset), .cart_loading(cart_loading),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .cart_id(cart_id), .cart_exrom(cart_exrom), .cart_game(cart_game),
      .cart_bank_num(cart_bank_num), .cart_bank_laddr(cart_bank_laddr),
      .cart_bank_size(cart_bank_size), .cart_bank_type(cart_bank_type),
      .cart_bank_raddr(cart_bank_raddr), .cart_bank_wr(cart_bank_wr),
      .cart_attached(cart_attached), .crt_error(crt_error), .chip_count(chip_count));

   always #5 clk32 = ~clk32;

   typedef struct packed {
      logic [15:0] num;
      logic [15:0] laddr;
      logic [15:0] size;
      logic [7:0]  typ;
      logic [24:0] raddr;
   } bank_t;

   bank_t       obs[$];
   bank_t       exp_q[$];
   logic [7:0]  file[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic        e_err, e_att, e_hdr_ok;
   int          e_cnt;
   logic [15:0] e_id;
   logic [7:0]  e_exrom, e_game;
   logic [7:0]  sig [16] = '{8'h43, 8'h36, 8'h34, 8'h20, 8'h43, 8'h41, 8'h52, 8'h54,
                             8'h52, 8'h49, 8'h44, 8'h47, 8'h45, 8'h20, 8'h20, 8'h20};

   // Record every bank strobe, sampled mid-cycle.
   always @(negedge clk32) begin
      if (cart_bank_wr)
         obs.push_back({cart_bank_num, cart_bank_laddr, cart_bank_size, cart_bank_type, cart_bank_raddr});
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void push_be(input logic [31:0] v, input int nb);
      for (int k = nb - 1; k >= 0; k--) file.push_back(v[8*k +: 8]);
   endfunction

   function automatic void make_header(input logic [31:0] hlen, input logic [15:0] id,
                                       input logic [7:0] exrom, input logic [7:0] game);
      int eff;
      file.delete();
      for (int k = 0; k < 16; k++) file.push_back(sig[k]);
      push_be(hlen, 4);
      push_be(32'h0100, 2);
      push_be({16'h0, id}, 2);
      file.push_back(exrom);
      file.push_back(game);
      eff = (hlen < 32'h40) ? 32'h40 : int'(hlen);
      while (file.size() < eff) file.push_back(8'h00);
   endfunction

   function automatic void add_chip(input logic [31:0] plen, input logic [15:0] typ,
                                    input logic [15:0] bank, input logic [15:0] laddr,
                                    input logic [15:0] size, input bit bad_tag);
      int np;
      push_be(32'h43484950 ^ (bad_tag ? 32'h1 : 32'h0), 4);
      push_be(plen, 4);
      push_be({16'h0, typ}, 2);
      push_be({16'h0, bank}, 2);
      push_be({16'h0, laddr}, 2);
      push_be({16'h0, size}, 2);
      np = (plen > 32'h10) ? int'(plen) - 16 : 0;
      for (int k = 0; k < np; k++) file.push_back(8'($urandom_range(0, 255)));
   endfunction

   function automatic int be32(input int p);
      return {file[p], file[p+1], file[p+2], file[p+3]};
   endfunction

   function automatic logic [15:0] be16(input int p);
      return {file[p], file[p+1]};
   endfunction

   // Walk the first n file bytes as the cartridge format describes them.
   function automatic void model(input int n);
      int  pos, hl, pl, cnt;
      bit  done;
      exp_q.delete();
      e_err = 0; e_att = 0; e_hdr_ok = 0; cnt = 0;
      for (int k = 0; k < 16 && k < n; k++) if (file[k] != sig[k]) e_err = 1;
      if (!e_err) begin
         if (n < 'h40) e_err = 1;
         else begin
            hl = be32(16);
            if (hl < 'h40) hl = 'h40;
            if (n < hl) e_err = 1;
            else begin
               e_hdr_ok = 1;
               e_id = be16('h16); e_exrom = file['h18]; e_game = file['h19];
               pos = hl; done = 0;
               while (!done) begin
                  if (pos == n) begin
                     if (cnt > 0) e_att = 1; else e_err = 1;
                     done = 1;
                  end else if (n - pos < 16) begin
                     e_err = 1; done = 1;
                  end else if (be32(pos) != 32'h43484950) begin
                     e_err = 1; done = 1;
                  end else begin
                     pl = be32(pos + 4);
                     if (pl < 16) begin
                        e_err = 1; done = 1;
                     end else begin
                        exp_q.push_back({be16(pos + 10), be16(pos + 12), be16(pos + 14),
                                         file[pos + 9], 25'(BASE + 25'(pos) + 25'd16)});
                        cnt++;
                        pos += pl;
                        if (pos > n) begin e_att = 1; done = 1; end
                     end
                  end
               end
            end
         end
      end
      e_cnt = (cnt > 255) ? 255 : cnt;
   endfunction

   task automatic check_load(input string tag, input int n);
      model(n);
      chk({tag, "_err"}, 128'(crt_error), 128'(e_err));
      chk({tag, "_att"}, 128'(cart_attached), 128'(e_att));
      chk({tag, "_cnt"}, 128'(chip_count), 128'(e_cnt));
      chk({tag, "_nstrobe"}, 128'(obs.size()), 128'(exp_q.size()));
      for (int k = 0; k < obs.size() && k < exp_q.size(); k++)
         chk({tag, "_bank"}, 128'(obs[k]), 128'(exp_q[k]));
      if (e_hdr_ok) begin
         chk({tag, "_id"}, 128'(cart_id), 128'(e_id));
         chk({tag, "_exrom"}, 128'(cart_exrom), 128'(e_exrom));
         chk({tag, "_game"}, 128'(cart_game), 128'(e_game));
      end
      if (e_att && exp_q.size() > 0)
         chk({tag, "_hold"}, 128'({cart_bank_num, cart_bank_laddr, cart_bank_size,
                                   cart_bank_type, cart_bank_raddr}),
             128'(exp_q[exp_q.size() - 1]));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_err"}, 128'(crt_error), 128'(0));
      chk({tag, "_att"}, 128'(cart_attached), 128'(0));
      chk({tag, "_cnt"}, 128'(chip_count), 128'(0));
      chk({tag, "_id"}, 128'(cart_id), 128'(0));
      chk({tag, "_exrom"}, 128'(cart_exrom), 128'(0));
      chk({tag, "_game"}, 128'(cart_game), 128'(0));
      chk({tag, "_bank"}, 128'({cart_bank_num, cart_bank_laddr, cart_bank_size, cart_bank_type}), 128'(0));
      chk({tag, "_raddr"}, 128'(cart_bank_raddr), 128'(0));
      chk({tag, "_wr"}, 128'(cart_bank_wr), 128'(0));
   endtask

   task automatic send(input int i);
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_data = file[i];
      @(posedge clk32); #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic run_load(input string tag, input int n_send, input bit gaps,
                           input bit rise_wb, input bit drop_wr);
      int i;
      obs.delete();
      i = 0;
      cart_loading = 1'b1;
      if (rise_wb && n_send > 0) begin
         ioctl_wr = 1'b1; ioctl_addr = '0; ioctl_data = file[0]; i = 1;
      end
      @(posedge clk32); #1;
      ioctl_wr = 1'b0;
      while (i < n_send) begin
         if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk32); #1; end
         send(i);
         i++;
      end
      cart_loading = 1'b0;
      if (drop_wr && n_send < file.size()) begin
         ioctl_wr = 1'b1; ioctl_addr = 25'(n_send); ioctl_data = file[n_send];
      end
      @(posedge clk32); #1;
      ioctl_wr = 1'b0;
      repeat (3) @(posedge clk32);
      #1;
      check_load(tag, n_send);
   endtask

   initial begin
      int          nch, hsel, nsend, ncut;
      logic [31:0] hl, plen;
      bit          bad;

      reset = 1'b1; cart_loading = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
      repeat (3) @(posedge clk32);
      #1 reset = 1'b0;
      @(posedge clk32); #1;
      check_zero("reset");

      // Plain 8K cartridge.
      make_header(32'h40, 16'd0, 8'd0, 8'd1);
      add_chip(32'h2010, 16'd0, 16'd0, 16'h8000, 16'h2000, 1'b0);
      run_load("8k", file.size(), 1'b1, 1'b0, 1'b0);
      chk("8k_raddr", 128'(obs.size() > 0 ? obs[0].raddr : 25'd0), 128'(BASE + 25'h50));
      chk("8k_game", 128'(cart_game), 128'(1));

      // EasyFlash, streamed back-to-back.
      make_header(32'h40, 16'd32, 8'd1, 8'd0);
      add_chip(32'h2010, 16'd2, 16'd0, 16'h8000, 16'h2000, 1'b0);
      add_chip(32'h2010, 16'd2, 16'd0, 16'hA000, 16'h2000, 1'b0);
      add_chip(32'h2010, 16'd2, 16'd1, 16'h8000, 16'h2000, 1'b0);
      add_chip(32'h2010, 16'd2, 16'd1, 16'hA000, 16'h2000, 1'b0);
      run_load("ef", file.size(), 1'b0, 1'b1, 1'b0);
      for (int k = 1; k < obs.size(); k++)
         chk("ef_step", 128'(obs[k].raddr - obs[k-1].raddr), 128'(25'h2010));

      // Corrupted signature.
      make_header(32'h40, 16'd0, 8'd0, 8'd1);
      add_chip(32'h0050, 16'd0, 16'd0, 16'h8000, 16'h0040, 1'b0);
      file[5] = 8'h00;
      run_load("badsig", file.size(), 1'b1, 1'b0, 1'b0);

      // Short header length field, plus a zero-payload chip.
      make_header(32'h20, 16'd5, 8'd0, 8'd0);
      add_chip(32'h0010, 16'd0, 16'd3, 16'hE000, 16'h0000, 1'b0);
      add_chip(32'h0050, 16'd0, 16'd70, 16'h8000, 16'h0040, 1'b0);
      run_load("hlen20", file.size(), 1'b1, 1'b0, 1'b1);

      // Packet length below the header size.
      make_header(32'h40, 16'd0, 8'd0, 8'd1);
      add_chip(32'h0030, 16'd0, 16'd0, 16'h8000, 16'h0020, 1'b0);
      add_chip(32'h0008, 16'd0, 16'd1, 16'h8000, 16'h0020, 1'b0);
      add_chip(32'h0030, 16'd0, 16'd2, 16'h8000, 16'h0020, 1'b0);
      run_load("plen08", file.size(), 1'b1, 1'b0, 1'b0);

      // Load ends inside the second payload.
      make_header(32'h40, 16'd0, 8'd0, 8'd1);
      for (int c = 0; c < 3; c++) add_chip(32'h0110, 16'd0, 16'(c), 16'h8000, 16'h0100, 1'b0);
      run_load("trunc", 'h40 + 'h110 + 16 + 'h50, 1'b1, 1'b0, 1'b1);

      // Reset mid-payload, rest of the stream must be ignored.
      make_header(32'h40, 16'd19, 8'd1, 8'd1);
      add_chip(32'h0110, 16'd0, 16'd4, 16'h8000, 16'h0100, 1'b0);
      add_chip(32'h0110, 16'd0, 16'd5, 16'h8000, 16'h0100, 1'b0);
      obs.delete();
      ncut = 'h40 + 16 + 'h80;
      cart_loading = 1'b1;
      @(posedge clk32); #1;
      for (int i = 0; i < ncut; i++) send(i);
      reset = 1'b1;
      repeat (2) @(posedge clk32);
      #1 reset = 1'b0;
      check_zero("rst_mid");
      obs.delete();
      for (int i = ncut; i < file.size(); i++) send(i);
      cart_loading = 1'b0;
      repeat (3) @(posedge clk32);
      #1;
      check_zero("rst_after");
      chk("rst_nostrobe", 128'(obs.size()), 128'(0));

      // Fresh load after the reset.
      make_header(32'h40, 16'd1, 8'd0, 8'd0);
      add_chip(32'h0090, 16'd0, 16'd0, 16'h8000, 16'h0080, 1'b0);
      add_chip(32'h0090, 16'd0, 16'd1, 16'hA000, 16'h0080, 1'b0);
      run_load("reload", file.size(), 1'b1, 1'b1, 1'b0);

      // Randomised images, corruptions and truncation points.
      for (int t = 0; t < 10; t++) begin
         hsel = $urandom_range(0, 2);
         hl = (hsel == 0) ? 32'h20 : (hsel == 1) ? 32'h40 : 32'h40 + $urandom_range(1, 16);
         make_header(hl, 16'($urandom_range(0, 63)), 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)));
         nch = $urandom_range(1, 4);
         for (int c = 0; c < nch; c++) begin
            plen = 32'h10 + $urandom_range(0, 48);
            if ($urandom_range(0, 9) == 0) plen = $urandom_range(0, 15);
            bad = ($urandom_range(0, 9) == 0);
            add_chip(plen, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 70)),
                     16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), bad);
         end
         nsend = ($urandom_range(0, 1) == 1) ? file.size() : int'($urandom_range(0, file.size()));
         run_load("rand", nsend, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
